// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter that shares one UART transmitter among
// NUM_REQ byte-stream requesters and sequences each byte through the tx_busy handshake.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ack,
  input  logic                 tx_busy,
  output logic                 uart_start,
  output logic [7:0]           uart_data,
  output logic [1:0]           grant,
  output logic                 grant_valid,
  output logic                 err
);

  localparam int CW = $clog2(BUSY_TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_e;

  state_e             state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic [1:0]         ptr_q, ptr_d;
  logic               grant_valid_q, grant_valid_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               last_q, last_d;
  logic               start_q, start_d;
  logic [7:0]         data_q, data_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               err_q, err_d;

  logic               found;
  logic [1:0]         winner;
  logic [1:0]         idx;
  logic               load_en;
  logic [1:0]         load_idx;
  logic [CW-1:0]      cnt_inc;

  // First requesting index in the circular order ptr, ptr+1, ...
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    ptr_d         = ptr_q;
    grant_valid_d = grant_valid_q;
    cnt_d         = cnt_q;
    last_d        = last_q;
    start_d       = 1'b0;
    data_d        = data_q;
    ack_d         = '0;
    err_d         = 1'b0;
    load_en       = 1'b0;
    load_idx      = grant_q;
    cnt_inc       = cnt_q + CW'(1);

    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d       = winner;
          grant_valid_d = 1'b1;
          load_en       = 1'b1;
          load_idx      = winner;
        end
      end
      LOAD: begin
        state_d = WAIT_BUSY;
        cnt_d   = '0;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else begin
          cnt_d = cnt_inc;
          // A transmitter that never answers costs this byte, not the packet.
          if (cnt_inc == CW'(BUSY_TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = WAIT_DONE;
          end
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (!last_q && req[grant_q]) begin
            load_en  = 1'b1;
            load_idx = grant_q;
          end else begin
            err_d         = !last_q;
            ptr_d         = grant_q + 2'd1;
            grant_valid_d = 1'b0;
            state_d       = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Byte and its last flag are captured on entry so they stay stable through LOAD.
    if (load_en) begin
      state_d = LOAD;
      start_d = 1'b1;
      ack_d   = NUM_REQ'(1) << load_idx;
      data_d  = req_data[{load_idx, 3'b000} +: 8];
      last_d  = req_last[load_idx];
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      ptr_q         <= '0;
      grant_valid_q <= 1'b0;
      cnt_q         <= '0;
      last_q        <= 1'b0;
      start_q       <= 1'b0;
      data_q        <= 8'h00;
      ack_q         <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      ptr_q         <= ptr_d;
      grant_valid_q <= grant_valid_d;
      cnt_q         <= cnt_d;
      last_q        <= last_d;
      start_q       <= start_d;
      data_q        <= data_d;
      ack_q         <= ack_d;
      err_q         <= err_d;
    end
  end

  assign req_ack     = ack_q;
  assign uart_start  = start_q;
  assign uart_data   = data_q;
  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign err         = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: behavioural requesters, a 10-cycle
// tx_busy transmitter model and per-scenario tasks with hand-computed expectations.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ack;
  logic        tx_busy;
  logic        uart_start;
  logic [7:0]  uart_data;
  logic [1:0]  grant;
  logic        grant_valid;
  logic        err;

  uart_tx_arbiter #(.NUM_REQ(4), .BUSY_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .req_ack(req_ack), .tx_busy(tx_busy), .uart_start(uart_start),
    .uart_data(uart_data), .grant(grant), .grant_valid(grant_valid), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] pkt [4][4];
  int         len [4];
  int         pos [4];
  int         drop_at [4];
  logic       active [4];
  logic       rpt [4];
  logic       model_en;
  int         busy_left;

  // Requester pins follow the behavioural packet state.
  always_comb begin
    req      = '0;
    req_data = '0;
    req_last = '0;
    for (int i = 0; i < 4; i++) begin
      req[i]            = active[i];
      req_data[8*i +: 8] = pkt[i][pos[i] % 4];
      req_last[i]       = (pos[i] == len[i] - 1);
    end
  end

  // Each ack advances the requester to its next byte.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (req_ack[i] && active[i]) begin
        pos[i] = pos[i] + 1;
        if (pos[i] >= len[i]) begin
          if (rpt[i]) pos[i] = 0;
          else        active[i] = 1'b0;
        end else if (drop_at[i] != 0 && pos[i] >= drop_at[i]) begin
          active[i] = 1'b0;
        end
      end
    end
  end

  // Transmitter: busy for 10 cycles starting the cycle after uart_start.
  always @(posedge clk or posedge rst) begin
    if (rst)                 busy_left <= 0;
    else if (!model_en)      busy_left <= 0;
    else if (uart_start)     busy_left <= 10;
    else if (busy_left > 0)  busy_left <= busy_left - 1;
  end
  assign tx_busy = (busy_left != 0);

  int         start_cnt;
  logic [7:0] data_log [16];
  logic [1:0] grant_log [16];
  int         ack_cnt [4];
  int         multi_ack;
  int         err_cnt;
  int         b2b;
  int         busy_fall_cyc;
  int         gv_fall_cyc;
  logic       prev_busy;
  logic       prev_gv;
  logic [1:0] prev_grant;

  always @(negedge clk) begin
    if (!rst) begin
      if (uart_start) begin
        if (start_cnt < 16) begin
          data_log[start_cnt]  = uart_data;
          grant_log[start_cnt] = grant;
        end
        start_cnt++;
      end
      for (int i = 0; i < 4; i++) if (req_ack[i]) ack_cnt[i]++;
      if ($countones(req_ack) > 1) multi_ack++;
      if (err) err_cnt++;
      if (prev_busy && !tx_busy) busy_fall_cyc = cyc;
      if (prev_gv && !grant_valid) gv_fall_cyc = cyc;
      if (prev_gv && grant_valid && grant != prev_grant) b2b++;
      prev_busy  = tx_busy;
      prev_gv    = grant_valid;
      prev_grant = grant;
    end
  end

  task automatic clear_logs();
    start_cnt     = 0;
    multi_ack     = 0;
    err_cnt       = 0;
    b2b           = 0;
    busy_fall_cyc = -1;
    gv_fall_cyc   = -1;
    prev_busy     = 1'b0;
    prev_gv       = 1'b0;
    prev_grant    = 2'd0;
    for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
    for (int i = 0; i < 16; i++) begin
      data_log[i]  = 8'h00;
      grant_log[i] = 2'd0;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      active[i]  = 1'b0;
      rpt[i]     = 1'b0;
      pos[i]     = 0;
      len[i]     = 1;
      drop_at[i] = 0;
      for (int j = 0; j < 4; j++) pkt[i][j] = 8'h00;
    end
    model_en = 1'b1;
  endtask

  task automatic load_pkt(input int i, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input int n, input int drop);
    pkt[i][0]  = b0;
    pkt[i][1]  = b1;
    pkt[i][2]  = b2;
    len[i]     = n;
    pos[i]     = 0;
    drop_at[i] = drop;
    rpt[i]     = 1'b0;
    active[i]  = 1'b1;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_logs();
    @(negedge clk);
  endtask

  task automatic wait_starts(input int n, input int limit, input string name);
    int k;
    k = 0;
    while (start_cnt < n && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (start_cnt < n) begin
      total++; bad++;
      $display("[TB] FAIL %s: timed out with %0d starts, need %0d", name, start_cnt, n);
    end
  endtask

  task automatic wait_gv_low(input int limit, input string name);
    int k;
    k = 0;
    while (grant_valid && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (grant_valid) begin
      total++; bad++;
      $display("[TB] FAIL %s: grant_valid still 1 after %0d cycles, need 0", name, limit);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_model();
    clear_logs();
    repeat (2) @(negedge clk);
    total++; if (uart_start !== 1'b0) begin bad++; $display("[TB] FAIL rst_start: got %b want 0", uart_start); end
    total++; if (uart_data !== 8'h00) begin bad++; $display("[TB] FAIL rst_data: got %h want 00", uart_data); end
    total++; if (grant !== 2'd0) begin bad++; $display("[TB] FAIL rst_grant: got %0d want 0", grant); end
    total++; if (grant_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_gv: got %b want 0", grant_valid); end
    total++; if (req_ack !== 4'b0000) begin bad++; $display("[TB] FAIL rst_ack: got %b want 0000", req_ack); end
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL rst_err: got %b want 0", err); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (grant_valid !== 1'b0) begin bad++; $display("[TB] FAIL idle_gv: got %b want 0", grant_valid); end
  endtask

  task automatic test_single();
    reset_dut();
    load_pkt(1, 8'h41, 8'h42, 8'h43, 3, 0);
    wait_starts(3, 200, "single_starts");
    wait_gv_low(60, "single_release");
    repeat (5) @(negedge clk);
    total++; if (start_cnt !== 3) begin bad++; $display("[TB] FAIL single_count: got %0d want 3", start_cnt); end
    total++; if (data_log[0] !== 8'h41) begin bad++; $display("[TB] FAIL single_b0: got %h want 41", data_log[0]); end
    total++; if (data_log[1] !== 8'h42) begin bad++; $display("[TB] FAIL single_b1: got %h want 42", data_log[1]); end
    total++; if (data_log[2] !== 8'h43) begin bad++; $display("[TB] FAIL single_b2: got %h want 43", data_log[2]); end
    total++; if (ack_cnt[1] !== 3) begin bad++; $display("[TB] FAIL single_acks: got %0d want 3", ack_cnt[1]); end
    total++; if (gv_fall_cyc - busy_fall_cyc !== 1) begin bad++; $display("[TB] FAIL single_release_time: got %0d want 1", gv_fall_cyc - busy_fall_cyc); end
    total++; if (grant !== 2'd1) begin bad++; $display("[TB] FAIL single_grant_hold: got %0d want 1", grant); end
    // Pointer now 2: of requesters 1 and 3, 3 must win first.
    clear_logs();
    load_pkt(1, 8'h51, 8'h00, 8'h00, 1, 0);
    load_pkt(3, 8'h53, 8'h00, 8'h00, 1, 0);
    wait_starts(2, 100, "single_ptr_starts");
    total++; if (grant_log[0] !== 2'd3) begin bad++; $display("[TB] FAIL single_ptr_first: got %0d want 3", grant_log[0]); end
    total++; if (grant_log[1] !== 2'd1) begin bad++; $display("[TB] FAIL single_ptr_second: got %0d want 1", grant_log[1]); end
  endtask

  task automatic test_round_robin();
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      load_pkt(i, 8'h30 + 8'(i), 8'h00, 8'h00, 1, 0);
      rpt[i] = 1'b1;
    end
    wait_starts(5, 400, "rr_starts");
    total++; if (grant_log[0] !== 2'd0) begin bad++; $display("[TB] FAIL rr_g0: got %0d want 0", grant_log[0]); end
    total++; if (grant_log[1] !== 2'd1) begin bad++; $display("[TB] FAIL rr_g1: got %0d want 1", grant_log[1]); end
    total++; if (grant_log[2] !== 2'd2) begin bad++; $display("[TB] FAIL rr_g2: got %0d want 2", grant_log[2]); end
    total++; if (grant_log[3] !== 2'd3) begin bad++; $display("[TB] FAIL rr_g3: got %0d want 3", grant_log[3]); end
    total++; if (grant_log[4] !== 2'd0) begin bad++; $display("[TB] FAIL rr_g4: got %0d want 0", grant_log[4]); end
    total++; if (data_log[2] !== 8'h32) begin bad++; $display("[TB] FAIL rr_data2: got %h want 32", data_log[2]); end
    total++; if (b2b !== 0) begin bad++; $display("[TB] FAIL rr_idle_gap: got %0d back-to-back grants want 0", b2b); end
    total++; if (multi_ack !== 0) begin bad++; $display("[TB] FAIL rr_onehot_ack: got %0d multi-acks want 0", multi_ack); end
  endtask

  task automatic test_packet_lock();
    int k;
    reset_dut();
    load_pkt(0, 8'h10, 8'h11, 8'h12, 3, 0);
    k = 0;
    while (ack_cnt[0] < 1 && k < 20) begin @(negedge clk); k++; end
    load_pkt(2, 8'h20, 8'h00, 8'h00, 1, 0);
    wait_starts(4, 300, "lock_starts");
    total++; if (grant_log[1] !== 2'd0) begin bad++; $display("[TB] FAIL lock_g1: got %0d want 0", grant_log[1]); end
    total++; if (grant_log[2] !== 2'd0) begin bad++; $display("[TB] FAIL lock_g2: got %0d want 0", grant_log[2]); end
    total++; if (grant_log[3] !== 2'd2) begin bad++; $display("[TB] FAIL lock_g3: got %0d want 2", grant_log[3]); end
    total++; if (data_log[2] !== 8'h12) begin bad++; $display("[TB] FAIL lock_d2: got %h want 12", data_log[2]); end
    total++; if (data_log[3] !== 8'h20) begin bad++; $display("[TB] FAIL lock_d3: got %h want 20", data_log[3]); end
  endtask

  task automatic test_timeout();
    int k;
    int t_start;
    int t_err;
    reset_dut();
    model_en = 1'b0;
    load_pkt(1, 8'h55, 8'h00, 8'h00, 1, 0);
    t_start = -1000;
    t_err   = -1;
    k = 0;
    while (t_start < 0 && k < 20) begin
      @(negedge clk);
      if (uart_start) t_start = cyc;
      k++;
    end
    k = 0;
    while (t_err < 0 && k < 40) begin
      @(negedge clk);
      if (err) t_err = cyc;
      k++;
    end
    total++; if (t_err - t_start !== 16) begin bad++; $display("[TB] FAIL tmo_delay: got %0d want 16", t_err - t_start); end
    @(negedge clk);
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL tmo_pulse: got %b want 0", err); end
    wait_gv_low(10, "tmo_release");
    repeat (3) @(negedge clk);
    total++; if (err_cnt !== 1) begin bad++; $display("[TB] FAIL tmo_err_count: got %0d want 1", err_cnt); end
    total++; if (start_cnt !== 1) begin bad++; $display("[TB] FAIL tmo_starts: got %0d want 1", start_cnt); end
    total++; if (grant_valid !== 1'b0) begin bad++; $display("[TB] FAIL tmo_gv: got %b want 0", grant_valid); end
  endtask

  task automatic test_abort();
    reset_dut();
    load_pkt(1, 8'h31, 8'h00, 8'h00, 1, 0);
    wait_starts(1, 20, "abort_pre");
    wait_gv_low(30, "abort_pre_release");
    repeat (2) @(negedge clk);
    clear_logs();
    load_pkt(3, 8'h60, 8'h61, 8'h62, 3, 1);
    wait_starts(1, 20, "abort_start");
    wait_gv_low(60, "abort_release");
    repeat (20) @(negedge clk);
    total++; if (err_cnt !== 1) begin bad++; $display("[TB] FAIL abort_err: got %0d want 1", err_cnt); end
    total++; if (start_cnt !== 1) begin bad++; $display("[TB] FAIL abort_starts: got %0d want 1", start_cnt); end
    total++; if (grant_valid !== 1'b0) begin bad++; $display("[TB] FAIL abort_gv: got %b want 0", grant_valid); end
    total++; if (grant_log[0] !== 2'd3) begin bad++; $display("[TB] FAIL abort_owner: got %0d want 3", grant_log[0]); end
    // Pointer wrapped to 0: requester 0 beats requester 3.
    clear_logs();
    load_pkt(0, 8'h70, 8'h00, 8'h00, 1, 0);
    load_pkt(3, 8'h73, 8'h00, 8'h00, 1, 0);
    wait_starts(1, 20, "abort_ptr_start");
    total++; if (grant_log[0] !== 2'd0) begin bad++; $display("[TB] FAIL abort_ptr: got %0d want 0", grant_log[0]); end
  endtask

  task automatic test_async_reset();
    reset_dut();
    load_pkt(1, 8'h31, 8'h00, 8'h00, 1, 0);
    wait_starts(1, 20, "arst_pre");
    wait_gv_low(30, "arst_pre_release");
    repeat (2) @(negedge clk);
    model_en = 1'b0;
    clear_logs();
    load_pkt(2, 8'h32, 8'h00, 8'h00, 1, 0);
    wait_starts(1, 20, "arst_start");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (grant_valid !== 1'b0) begin bad++; $display("[TB] FAIL arst_gv: got %b want 0", grant_valid); end
    total++; if (grant !== 2'd0) begin bad++; $display("[TB] FAIL arst_grant: got %0d want 0", grant); end
    total++; if (uart_data !== 8'h00) begin bad++; $display("[TB] FAIL arst_data: got %h want 00", uart_data); end
    total++; if (uart_start !== 1'b0) begin bad++; $display("[TB] FAIL arst_start: got %b want 0", uart_start); end
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL arst_err: got %b want 0", err); end
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    load_pkt(1, 8'h41, 8'h00, 8'h00, 1, 0);
    load_pkt(2, 8'h42, 8'h00, 8'h00, 1, 0);
    wait_starts(1, 20, "arst_after");
    total++; if (grant_log[0] !== 2'd1) begin bad++; $display("[TB] FAIL arst_ptr: got %0d want 1", grant_log[0]); end
    total++; if (data_log[0] !== 8'h41) begin bad++; $display("[TB] FAIL arst_data_after: got %h want 41", data_log[0]); end
    total++; if (err_cnt !== 0) begin bad++; $display("[TB] FAIL arst_no_err: got %0d want 0", err_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_packet_lock();
    test_timeout();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
